// File: rtl/seg_scanner.sv
// seg_scanner: time-multiplexed scan controller for a common-anode 7-segment display.
// Optional leading-zero blanking: SEG_SCANNER_LEADING_ZERO_BLANK_EN. Rev 1.0
`default_nettype none

module seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 12000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  output logic [3:0]              nibble,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_n;
  logic [4*NUM_DIGITS-1:0] active, active_n;
  logic                    pending, pending_n;
  logic                    cnt_wrap, frame_wrap;
  logic [NUM_DIGITS-1:0]   lit;
  logic [NUM_DIGITS-1:0]   sel_n;

  // Outputs are registered from the next-state values so they line up with cnt/idx.
  always_comb begin
    cnt_wrap   = (cnt == CNT_MAX);
    frame_wrap = cnt_wrap && (idx == IDX_MAX);
    cnt_n      = cnt_wrap ? '0 : cnt + CNT_W'(1);
    idx_n      = idx;
    if (cnt_wrap) begin
      idx_n = frame_wrap ? '0 : idx + IDX_W'(1);
    end

    shadow_n  = shadow;
    pending_n = pending;
    active_n  = active;
    if (load) begin
      shadow_n  = value;
      pending_n = 1'b1;
    end
    // A load on the frame boundary bypasses the shadow and lands in the new frame.
    if (frame_wrap) begin
      if (load) begin
        active_n  = value;
        pending_n = 1'b0;
      end else if (pending) begin
        active_n  = shadow;
        pending_n = 1'b0;
      end
    end
  end

`ifdef SEG_SCANNER_LEADING_ZERO_BLANK_EN
  logic seen_nz;

  always_comb begin
    lit     = '0;
    seen_nz = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen_nz = seen_nz | (active_n[4*i +: 4] != 4'h0);
      lit[i]  = seen_nz | (i == 0);
    end
  end
`else
  assign lit = '1;
`endif

  always_comb begin
    sel_n = '1;
    if ((cnt_n >= BLANK_END) && lit[idx_n]) begin
      sel_n[idx_n] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      shadow     <= '0;
      active     <= '0;
      pending    <= 1'b0;
      nibble     <= 4'h0;
      digit_sel  <= '1;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_n;
      idx        <= idx_n;
      shadow     <= shadow_n;
      active     <= active_n;
      pending    <= pending_n;
      nibble     <= active_n[4*idx_n +: 4];
      digit_sel  <= sel_n;
      frame_done <= (idx_n == IDX_MAX) && (cnt_n == CNT_MAX);
    end
  end

endmodule

`default_nettype wire
